// File: rtl/pipe_stage_elastic.sv
// Elastic multi-slot pipeline register with a valid/ready handshake, bubble collapse,
// synchronous flush that zeroes control, an occupancy count and a saturating flush-kill count.
module pipe_stage_elastic #(
  parameter int CTRL_W     = 5,
  parameter int DATA_W     = 105,
  parameter int DEPTH      = 1,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int KILL_W     = 8,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [KILL_W-1:0] kill_cnt
);
  localparam int SUM_W = KILL_W + OCC_W + 1;
  localparam logic [SUM_W-1:0] KILL_MAX = SUM_W'({KILL_W{1'b1}});

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q   [DEPTH];
  logic [CTRL_W-1:0] ctrl_d   [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] data_d   [DEPTH];
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  load;
  logic              accept;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [KILL_W-1:0] kill_q, kill_d;
  logic [SUM_W-1:0]  kill_sum;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // A valid slot moves unless every slot ahead of it is full and the output is stalled.
      localparam logic [DEPTH-1:0] AT_OR_BEHIND = DEPTH'((1 << (gi + 1)) - 1);
      assign adv[gi] = valid_q[gi] & (out_ready | ~&(valid_q | AT_OR_BEHIND));

      if (gi == 0) begin : g_head
        assign load[gi]     = accept;
        assign src_ctrl[gi] = in_ctrl;
        assign src_data[gi] = in_data;
      end else begin : g_tail
        assign load[gi]     = adv[gi-1];
        assign src_ctrl[gi] = ctrl_q[gi-1];
        assign src_data[gi] = data_q[gi-1];
      end

      a_idle_ctrl_zero: assert property (@(posedge clk) disable iff (!rst_n)
                                         !valid_q[gi] |-> (ctrl_q[gi] == '0));
    end
  endgenerate

  assign in_ready = ~flush & (~valid_q[0] | adv[0]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      ctrl_d[i]  = ctrl_q[i];
      data_d[i]  = data_q[i];
      if (flush || (adv[i] && !load[i])) begin
        valid_d[i] = 1'b0;
        ctrl_d[i]  = '0;
        if (CLEAR_DATA) data_d[i] = '0;
      end else if (load[i]) begin
        valid_d[i] = 1'b1;
        ctrl_d[i]  = src_ctrl[i];
        data_d[i]  = src_data[i];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !adv[DEPTH-1]) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && adv[DEPTH-1]) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Entries lost to a flush are the valid slots at the flush edge.
  always_comb begin
    kill_sum = SUM_W'(kill_q);
    for (int i = 0; i < DEPTH; i++) begin
      kill_sum = kill_sum + SUM_W'(valid_q[i]);
    end
    kill_d = kill_q;
    if (flush) begin
      kill_d = (kill_sum > KILL_MAX) ? KILL_MAX[KILL_W-1:0] : kill_sum[KILL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      kill_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      kill_q  <= kill_d;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= ctrl_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign kill_cnt  = kill_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives four elastic stages (DEPTH 1..4, mixed CLEAR_DATA/KILL_W) from one stimulus stream
// and compares each against an entry-queue reference model.
module tb_pipe_stage_elastic;
  localparam int CW = 5;
  localparam int DW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic [N-1:0]  in_ready_w, out_valid_w;
  logic [CW-1:0] out_ctrl_w [N];
  logic [DW-1:0] out_data_w [N];
  logic [2:0]    occ_w      [N];
  logic [7:0]    kill_w     [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int D  = gi + 1;
    localparam bit CL = ((gi % 2) == 0);
    localparam int KW = (gi == 1) ? 2 : 8;
    logic [$clog2(D+1)-1:0] occ_l;
    logic [KW-1:0]          kill_l;
    pipe_stage_elastic #(
      .CTRL_W(CW), .DATA_W(DW), .DEPTH(D), .CLEAR_DATA(CL), .KILL_W(KW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_w[gi]),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid_w[gi]), .out_ready(out_ready),
      .out_ctrl(out_ctrl_w[gi]), .out_data(out_data_w[gi]),
      .occupancy(occ_l), .kill_cnt(kill_l)
    );
    assign occ_w[gi]  = 3'(occ_l);
    assign kill_w[gi] = 8'(kill_l);
  end

  // Reference model: per DUT, the entries in flight, oldest first, each with its slot position.
  int            m_n    [N];
  int            m_pos  [N][4];
  logic [CW-1:0] m_ctrl [N][4];
  logic [DW-1:0] m_data [N][4];
  logic [DW-1:0] m_last [N];
  int            m_kill [N];

  int checks   = 0;
  int failures = 0;
  int nstep    = 0;

  function automatic int depth_of(input int k);  return k + 1;            endfunction
  function automatic bit clear_of(input int k);  return (k % 2) == 0;     endfunction
  function automatic int kmax_of(input int k);   return (k == 1) ? 3 : 255; endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_n[k]    = 0;
      m_last[k] = '0;
      m_kill[k] = 0;
    end
  endtask

  // One clock edge of the model; returns whether the stage is ready for the offered input.
  task automatic model_step(input int k, input bit iv, input bit fl, input bit ordy, output bit rdy);
    int            d;
    int            ahead;
    int            nn;
    int            p;
    int            nxt;
    int            np [4];
    logic [CW-1:0] nc [4];
    logic [DW-1:0] nd [4];
    d     = depth_of(k);
    ahead = d;
    nn    = 0;
    for (int e = 0; e < m_n[k]; e++) begin
      p = m_pos[k][e];
      if (!(e == 0 && p == d - 1 && ordy)) begin
        nxt    = (p + 1 <= ahead - 1) ? p + 1 : ahead - 1;
        np[nn] = nxt;
        nc[nn] = m_ctrl[k][e];
        nd[nn] = m_data[k][e];
        nn++;
        ahead  = nxt;
      end
    end
    rdy = !fl && (nn == 0 || np[nn-1] != 0);
    if (fl) begin
      m_kill[k] = (m_kill[k] + m_n[k] > kmax_of(k)) ? kmax_of(k) : m_kill[k] + m_n[k];
      nn = 0;
    end else if (iv && rdy) begin
      np[nn] = 0;
      nc[nn] = in_ctrl;
      nd[nn] = in_data;
      nn++;
    end
    m_n[k] = nn;
    for (int e = 0; e < nn; e++) begin
      m_pos[k][e]  = np[e];
      m_ctrl[k][e] = nc[e];
      m_data[k][e] = nd[e];
    end
    if (nn > 0 && np[0] == d - 1) m_last[k] = nd[0];
  endtask

  task automatic check_out(input int k);
    bit v;
    v = (m_n[k] > 0) && (m_pos[k][0] == depth_of(k) - 1);
    chk("out_valid", k, out_valid_w[k], v);
    chk("out_ctrl",  k, out_ctrl_w[k], v ? m_ctrl[k][0] : '0);
    chk("out_data",  k, out_data_w[k], v ? m_data[k][0] : (clear_of(k) ? '0 : m_last[k]));
    chk("occupancy", k, occ_w[k], m_n[k]);
    chk("kill_cnt",  k, kill_w[k], m_kill[k]);
  endtask

  task automatic step(input bit iv, input bit fl, input bit ordy,
                      input logic [CW-1:0] c, input logic [DW-1:0] dt);
    bit rdy;
    @(negedge clk);
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = dt;
    #1;
    for (int k = 0; k < N; k++) begin
      model_step(k, iv, fl, ordy, rdy);
      chk("in_ready", k, in_ready_w[k], rdy);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check_out(k);
    $display("step %0d iv=%0b fl=%0b ordy=%0b ctrl=%02h data=%08h out_valid=%b occ0..3=%0d/%0d/%0d/%0d",
             nstep, iv, fl, ordy, c, dt, out_valid_w, occ_w[0], occ_w[1], occ_w[2], occ_w[3]);
    nstep++;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_out_valid", k, out_valid_w[k], 1'b0);
      chk("rst_out_ctrl",  k, out_ctrl_w[k], '0);
      chk("rst_out_data",  k, out_data_w[k], '0);
      chk("rst_occupancy", k, occ_w[k], 0);
      chk("rst_kill_cnt",  k, kill_w[k], 0);
    end
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset applied and released");
  endtask

  initial begin
    int kexp [3];
    kexp = '{2, 3, 3};
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check_out(k);
    @(negedge clk);
    rst_n = 1'b1;

    // Single entry through the DEPTH=1 stage, then an idle cycle.
    step(1'b1, 1'b0, 1'b1, 5'b10110, 32'h1234);
    chk("t1_out_ctrl", 0, out_ctrl_w[0], 5'b10110);
    chk("t1_out_data", 0, out_data_w[0], 32'h1234);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("t1_idle_valid", 0, out_valid_w[0], 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, '0, '0);

    // Back-to-back stream of six entries.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 5'($urandom), 32'h100 + i);
    repeat (5) step(1'b0, 1'b0, 1'b1, '0, '0);

    // Stall with offered entries, then release.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 5'($urandom), 32'h200 + i);
    chk("t3_occupancy", 2, occ_w[2], 3);
    chk("t3_in_ready",  2, in_ready_w[2], 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 5'($urandom), 32'h300 + i);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0, '0);

    // Fill, then flush with a same-cycle offer; the KILL_W=2 stage saturates.
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b0, 1'b0, 5'($urandom), 32'h400 + 2 * r);
      step(1'b1, 1'b0, 1'b0, 5'($urandom), 32'h401 + 2 * r);
      step(1'b1, 1'b1, 1'b0, 5'h1f, 32'hdead);
      chk("t5_kill_cnt", 1, kill_w[1], kexp[r]);
    end
    step(1'b0, 1'b1, 1'b1, '0, '0);

    // Random traffic with an asynchronous reset in the middle of toggling backpressure.
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
           5'($urandom), $urandom);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i[0], 5'($urandom), $urandom);
    async_reset();
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
           5'($urandom), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (EX/MEM class).
- Carries a control bundle and a data bundle through DEPTH register slots, using a valid/ready handshake.
- Adds stall (backpressure), bubble collapsing, synchronous flush with zeroed control, an occupancy count and a flush-kill counter.
- Sits between any two core stages, e.g. EX->MEM with CTRL_W=5 (Branch, MemRead, MemtoReg, MemWrite, RegWrite) and DATA_W=32+32+1+32+5+3.

Parameters:
- CTRL_W, 5, width of control bundle; always cleared to 0 on bubble or flush.
- DATA_W, 105, width of data bundle.
- DEPTH, 1, number of slots, legal 1..4.
- CLEAR_DATA, 1, 1 = data zeroed on flush/bubble; 0 = data holds its last value.
- KILL_W, 8, width of the saturating flush-kill counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an entry
- in_ready  out  1  slot 0 can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- flush  in  1  synchronous kill of all slots and of the input
- out_valid  out  1  last slot holds an entry
- out_ready  in  1  downstream consumes
- out_ctrl  out  CTRL_W  last slot control
- out_data  out  DATA_W  last slot data
- occupancy  out  $clog2(DEPTH+1)  number of valid slots
- kill_cnt  out  KILL_W  valid entries discarded by flush, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All slot valids 0; all ctrl and data 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, kill_cnt=0.
  - Leaving reset is synchronous to the next clk edge.
- Slots 0..DEPTH-1: slot 0 takes input, slot DEPTH-1 drives the outputs. All outputs are registered except in_ready.
- Advance rules, evaluated combinationally from the last slot backwards:
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready.
  - adv[i] = valid[i] & (~valid[i+1] | adv[i+1]).
  - An entry moves one slot per edge; bubbles collapse.
- in_ready = ~flush & (~valid[0] | adv[0]). Accept occurs when in_valid & in_ready.
- When a slot loses its entry and nothing refills it:
  - valid <= 0 and ctrl <= 0.
  - data <= 0 if CLEAR_DATA=1, else data holds.
- Invariant: an invalid slot always presents ctrl=0. This is checked by assertion.
- Latency: empty pipe with out_ready=1: entry presented in cycle n appears at the output in cycle n+DEPTH. Throughput is 1 entry/cycle sustained.
- Stall: with out_ready=0 the last slot holds its values stable. Upstream slots fill until all are valid, then in_ready=0.
- Flush (highest priority over all handshakes):
  - At the edge, all valids, all ctrl and (if CLEAR_DATA) all data go to 0.
  - The same-cycle input is not accepted (in_ready=0).
  - The same-cycle output is still presented; downstream must ignore out_valid while flush=1. This is a system rule.
  - occupancy <= 0.
  - kill_cnt <= sat(kill_cnt + popcount(valid)).
- Flush with an empty pipe: state unchanged apart from zeroing; kill_cnt is unchanged.
- occupancy' = occupancy + accept - (adv[DEPTH-1]); never exceeds DEPTH.
- kill_cnt saturates at 2^KILL_W-1 and does not wrap. It is cleared only by reset.
- Reset asserted mid-transfer: all entries are lost immediately and are not counted in kill_cnt.
- Simultaneous accept and output pop with all slots full: legal, and occupancy is unchanged.

Test Plan:
1. DEPTH=1, CLEAR_DATA=1, out_ready=1: present ctrl=5'b10110, data=0x1234 in cycle 0 -> out_valid=1, out_ctrl=5'b10110, out_data=0x1234 in cycle 1. In cycle 2 (no input) out_valid=0, ctrl=0, data=0.
2. DEPTH=3, stream 6 entries back-to-back with out_ready=1 -> first output at cycle 3 and outputs on 6 consecutive cycles in order. in_ready stays 1 and occupancy peaks at 3.
3. DEPTH=3: hold out_ready=0 and offer 5 entries -> 3 accepted, in_ready=0 from cycle 3, occupancy=3, out_data stable. Raise out_ready -> remaining 2 accepted, all 5 delivered in order with none duplicated.
4. DEPTH=2 with 2 valid entries: assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, kill_cnt=2. The offered input is not accepted and in_ready=0 during flush.
5. KILL_W=2: three flushes each killing 2 entries -> kill_cnt = 2, 3, 3 (saturated).
6. DEPTH=4 with 3 entries in flight and out_ready toggling: assert rst_n=0 asynchronously mid-cycle -> outputs zero before the next clk edge, occupancy=0, kill_cnt=0. Traffic resumes cleanly after release.
